// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register with registered o_ready; latency 1 cycle in to out.
// Absorbs one cycle of downstream stall in the skid word. Optional PIPE_SKID_REG_FLUSH_EN adds i_flush.
module pipe_skid_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef PIPE_SKID_REG_FLUSH_EN
  input  logic             i_flush,
`endif
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [1:0]       o_level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = i_valid & ready_q;
  assign out_xfer = valid_q & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = i_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = i_data;
        end else if (in_xfer) begin
          skid_d  = i_data;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
`ifdef PIPE_SKID_REG_FLUSH_EN
    // Flush drops occupancy only; the data words keep their last contents.
    if (i_flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
`endif
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_data  = main_q;
  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_level = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg; define PIPE_SKID_REG_FLUSH_EN to also exercise i_flush.
module tb_pipe_skid_reg;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic [1:0] o_level;
`ifdef PIPE_SKID_REG_FLUSH_EN
  logic       i_flush = 1'b0;
`endif

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb[$];
  logic [7:0] m_data = 8'h00;
  int         m_level = 0;

  pipe_skid_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
`ifdef PIPE_SKID_REG_FLUSH_EN
    .i_flush (i_flush),
`endif
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_level (o_level)
  );

  always #5 clk = ~clk;

  // Advance one edge: predict IN/OUT from the model, pop/compare on OUT, push on IN.
  task automatic tick();
    logic       in_x, out_x, fl;
    logic [7:0] exp_d;
    logic [1:0] lv;
    fl = 1'b0;
`ifdef PIPE_SKID_REG_FLUSH_EN
    fl = i_flush;
`endif
    in_x  = i_valid && (m_level != 2);
    out_x = (m_level != 0) && i_ready;
    if (i_rst) begin
      sb.delete();
      m_data = 8'h00;
    end else if (fl) begin
      sb.delete();
    end else begin
      if (out_x) begin
        exp_d = sb.pop_front();
        total++;
        if (o_data !== exp_d) begin
          bad++;
          $display("FAIL out_word got=%h want=%h", o_data, exp_d);
        end
      end
      if (in_x) sb.push_back(i_data);
    end
    m_level = sb.size();
    if (m_level != 0) m_data = sb[0];
    lv = m_level[1:0];
    @(posedge clk);
    #1;
    total++;
    if ({o_valid, o_ready, o_level} !== {(lv != 2'd0), (lv != 2'd2), lv}) begin
      bad++;
      $display("FAIL flags got v=%b r=%b l=%0d want v=%b r=%b l=%0d",
               o_valid, o_ready, o_level, (lv != 2'd0), (lv != 2'd2), lv);
    end
    total++;
    if (o_data !== m_data) begin
      bad++;
      $display("FAIL data_reg got=%h want=%h", o_data, m_data);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_data = 8'hAA; i_ready = 1'b0;
    tick(); tick();
    total++;
    if ({o_valid, o_ready, o_level, o_data} !== {1'b0, 1'b1, 2'd0, 8'h00}) begin
      bad++;
      $display("FAIL reset_state got v=%b r=%b l=%0d d=%h want 0 1 0 00", o_valid, o_ready, o_level, o_data);
    end
    i_rst = 1'b0; i_valid = 1'b0;
    tick(); tick();
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got v=%b want 0", o_valid);
    end
  endtask

  task automatic test_streaming();
    i_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      i_valid = 1'b1; i_data = 8'(k);
      tick();
      total++;
      if (o_data !== 8'(k) || o_level !== 2'd1 || o_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d got d=%h l=%0d r=%b want d=%h l=1 r=1", k, o_data, o_level, o_ready, 8'(k));
      end
    end
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    i_ready = 1'b0; i_valid = 1'b1;
    i_data = 8'h11; tick();
    i_data = 8'h22; tick();
    total++;
    if (o_level !== 2'd2 || o_ready !== 1'b0 || o_data !== 8'h11) begin
      bad++;
      $display("FAIL bp_full got l=%0d r=%b d=%h want l=2 r=0 d=11", o_level, o_ready, o_data);
    end
    i_data = 8'h33; tick();
    total++;
    if (o_level !== 2'd2) begin
      bad++;
      $display("FAIL bp_reject got l=%0d want 2", o_level);
    end
    i_ready = 1'b1;
    tick();
    total++;
    if (o_data !== 8'h22 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got d=%h r=%b want d=22 r=1", o_data, o_ready);
    end
    tick();
    total++;
    if (o_data !== 8'h33) begin
      bad++;
      $display("FAIL bp_third got d=%h want 33", o_data);
    end
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_drain();
    i_ready = 1'b0; i_valid = 1'b1; i_data = 8'h5A;
    tick();
    i_valid = 1'b0; i_ready = 1'b1;
    tick();
    total++;
    if (o_valid !== 1'b0 || o_level !== 2'd0 || o_data !== 8'h5A) begin
      bad++;
      $display("FAIL drain got v=%b l=%0d d=%h want v=0 l=0 d=5a", o_valid, o_level, o_data);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0; i_valid = 1'b1;
    i_data = 8'hC1; tick();
    i_data = 8'hC2; tick();
    i_valid = 1'b0; i_ready = 1'b1; i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (o_valid !== 1'b0 || o_data !== 8'h00) begin
        bad++;
        $display("FAIL rst_mid_%0d got v=%b d=%h want v=0 d=00", k, o_valid, o_data);
      end
    end
  endtask

`ifdef PIPE_SKID_REG_FLUSH_EN
  task automatic test_flush();
    i_ready = 1'b0; i_valid = 1'b1;
    i_data = 8'h61; tick();
    i_data = 8'h62; tick();
    i_data = 8'h77; i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    total++;
    if (o_level !== 2'd0 || o_data !== 8'h61) begin
      bad++;
      $display("FAIL flush got l=%0d d=%h want l=0 d=61", o_level, o_data);
    end
    i_valid = 1'b1; i_data = 8'h44; tick();
    i_valid = 1'b0; i_rst = 1'b1; i_flush = 1'b1;
    tick();
    i_rst = 1'b0; i_flush = 1'b0;
    total++;
    if (o_data !== 8'h00 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_rst got d=%h v=%b want d=00 v=0", o_data, o_valid);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 3) != 0);
      i_data  = i_valid ? 8'($urandom) : 8'hxx;
      tick();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_drain();
    test_reset_mid();
`ifdef PIPE_SKID_REG_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-entry elastic pipeline register: the consumer-side counterpart to the plain free-running D register.
- Accepts data from an upstream writer with a valid/ready handshake and presents it to a downstream reader with valid/ready.
- Absorbs one cycle of downstream back-pressure without data loss, so o_ready is driven purely from a flop (no combinational ready path from i_ready).
- Used between processor pipeline stages and between bus-side producers and consumers.

Parameters:
- WIDTH, 8, data bits per transfer.
- RESET_VALUE, {WIDTH{1'b0}}, value of o_data and of the internal skid data register after reset.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_data  input  WIDTH  upstream data.
- i_valid  input  1  upstream data valid.
- o_ready  output  1  block can accept; registered.
- o_data  output  WIDTH  downstream data; registered.
- o_valid  output  1  downstream data valid; registered.
- i_ready  input  1  downstream can accept.
- o_level  output  2  entries held: 0, 1 or 2.

Behaviour:
- Handshakes:
  - Upstream transfer (IN) = i_valid & o_ready.
  - Downstream transfer (OUT) = o_valid & i_ready.
  - Both are sampled at the rising edge.
- Storage: main register drives o_data; skid register holds a second word.
- States: EMPTY (level 0), ONE (level 1, main holds data), FULL (level 2, main and skid hold data).
- Reset (i_rst=1 at edge):
  - State EMPTY; o_valid=0, o_ready=1, o_level=0, o_data=RESET_VALUE, skid=RESET_VALUE.
  - Reset overrides any concurrent IN/OUT. Data mid-transfer is discarded and no transfer is counted.
- Transitions:
  - EMPTY, IN -> ONE; main<=i_data.
  - EMPTY, no IN -> EMPTY.
  - ONE, IN & OUT -> ONE; main<=i_data (back-to-back streaming, full throughput).
  - ONE, IN & !OUT -> FULL; skid<=i_data; main unchanged.
  - ONE, !IN & OUT -> EMPTY; main unchanged (stale value held, o_valid=0).
  - ONE, neither -> ONE.
  - FULL: o_ready=0, so no IN is possible.
    - OUT -> ONE; main<=skid.
    - Otherwise hold.
- Output derivation (all registered from next state):
  - o_valid = (state != EMPTY).
  - o_ready = (state != FULL).
  - o_level equals the state encoding.
- Latency: a word accepted at edge N appears on o_data/o_valid after edge N; it can be consumed at edge N+1 at the earliest.
- Ordering: strict FIFO; no duplication, no loss.
- i_valid while o_ready=0: ignored; the upstream must hold its data.
- o_data is stable while o_valid=1 and i_ready=0.
- i_data is don't-care when i_valid=0. X on i_data must not corrupt state unless IN occurs.

Optional Feature:
- Macro PIPE_SKID_REG_FLUSH_EN.
- Defined:
  - Adds input i_flush (1 bit).
  - i_flush=1 at an edge forces state EMPTY, o_valid=0, o_ready=1, o_level=0.
  - o_data and skid keep their values.
  - Any concurrent IN or OUT is dropped.
  - i_rst has priority over i_flush.
- Undefined: no i_flush port; behaviour is exactly as above.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles with i_valid=1, i_data=8'hAA -> o_valid=0, o_ready=1, o_level=0, o_data=8'h00. After release with no input, state stays EMPTY.
- Streaming: i_ready=1 constant; drive 8'h01..8'h10 on consecutive cycles with i_valid=1 -> o_ready stays 1, o_level stays 1, o_data sequence 01..10 one cycle later, no gaps.
- Back-pressure:
  - Send 8'h11, 8'h22 with i_ready=0 -> o_level=2, o_ready=0, o_data=11; 8'h33 offered on the next cycle is not accepted.
  - Then set i_ready=1 -> outputs 11, 22, 33 in order; o_ready returns to 1 one cycle after the first OUT.
- Drain to empty: level 1 holding 8'h5A, i_valid=0, i_ready=1 -> after one edge o_valid=0, o_level=0, o_data still 8'h5A.
- Reset mid-operation: FULL with 8'hC1/8'hC2, i_rst=1 for one cycle while i_ready=1 -> EMPTY, o_data=8'h00, neither C1 nor C2 is observed after reset.
- Flush (with PIPE_SKID_REG_FLUSH_EN defined): FULL state, i_flush=1 together with i_valid=1, i_data=8'h77 -> EMPTY, 8'h77 not captured. With both i_rst=1 and i_flush=1 -> reset values.
